// File: rtl/relu_maxpool2d_stream.sv
// ReLU followed by 2x2 stride-2 max-pooling on a raster stream of FP32 pixels.
// Max is a bit-pattern compare, exact for the non-negative values left after ReLU.
module relu_maxpool2d_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH)     : 1;
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT)    : 1;
    localparam int LW = (WIDTH  > 2) ? $clog2(WIDTH / 2) : 1;
    localparam int LD = WIDTH / 2;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? '0 : x;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] h_q;
    logic [DATA_WIDTH-1:0] lbuf_q [LD];
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_out_q;
    logic                  frame_done_q;
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] h;
    logic [LW-1:0]         lidx;
    logic                  col_last;
    logic                  row_last;

    always_comb begin
        r        = relu(data_in);
        h        = fmax(h_q, r);
        lidx     = LW'(col_q >> 1);
        col_last = (col_q == CW'(WIDTH - 1));
        row_last = (row_q == RW'(HEIGHT - 1));
        col_d    = col_q;
        row_d    = row_q;
        if (valid_in) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (valid_in) begin
                if (!col_q[0]) begin
                    h_q <= r;
                end else if (row_q[0]) begin
                    data_out_q   <= fmax(lbuf_q[lidx], h);
                    valid_out_q  <= 1'b1;
                    frame_done_q <= row_last && col_last;
                end
            end
        end
    end

    // Even rows park their horizontal maxima; the following odd row reads them back.
    always_ff @(posedge clk) begin
        if (!rst && valid_in && col_q[0] && !row_q[0]) begin
            lbuf_q[lidx] <= h;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2d_stream.sv
// Bench for relu_maxpool2d_stream: a 4x4 instance driven from a vector table and a
// default 56x56 instance driven with random FP32 data against a relu+pool reference.
module tb_relu_maxpool2d_stream;

    typedef struct packed {
        logic [15:0][31:0] px;
        logic [3:0][31:0]  ex;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        fd;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_din = '0;
    logic        s_vin = 1'b0;
    logic [31:0] s_dout;
    logic        s_vout, s_fd;
    logic [31:0] b_din = '0;
    logic        b_vin = 1'b0;
    logic [31:0] b_dout;
    logic        b_vout, b_fd;

    logic [31:0] cyc = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          b_pulses = 0;
    exp_t        sq[$];
    exp_t        bq[$];
    exp_t        s_e, b_e;
    vec_t        tbl[6];
    logic [31:0] bpx[3136];
    logic [31:0] bref[784];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    relu_maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) dut_s (
        .clk(clk), .rst(rst), .data_in(s_din), .valid_in(s_vin),
        .data_out(s_dout), .valid_out(s_vout), .frame_done(s_fd));

    relu_maxpool2d_stream dut_b (
        .clk(clk), .rst(rst), .data_in(b_din), .valid_in(b_vin),
        .data_out(b_dout), .valid_out(b_vout), .frame_done(b_fd));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] fp(input int n);
        logic [31:0] m;
        int          e;
        logic        s;
        s = (n < 0);
        m = s ? 32'(-n) : 32'(n);
        if (m == 0) return 32'h0;
        e = 31;
        while (!m[e]) e--;
        return {s, 8'(127 + e), 23'(m << (23 - e))};
    endfunction

    function automatic logic [15:0][31:0] pk(input int v[16]);
        logic [15:0][31:0] p;
        for (int i = 0; i < 16; i++) p[i] = fp(v[i]);
        return p;
    endfunction

    function automatic logic [3:0][31:0] pk4(input int a, input int b, input int c, input int d);
        logic [3:0][31:0] p;
        p[0] = fp(a); p[1] = fp(b); p[2] = fp(c); p[3] = fp(d);
        return p;
    endfunction

    function automatic logic [31:0] ref_relu(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    always @(negedge clk) begin
        if (s_vout) begin
            if (sq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL small_spurious: valid_out with data %h, required no pulse", s_dout);
            end else begin
                s_e = sq.pop_front();
                chk("small_data", s_dout, s_e.d);
                chk("small_frame_done", 32'(s_fd), 32'(s_e.fd));
                chk("small_latency", cyc, s_e.cyc);
            end
        end else if (s_fd) begin
            n_chk++; n_fail++;
            $display("FAIL small_fd_alone: frame_done 1 without valid_out, required 0");
        end
    end

    always @(negedge clk) begin
        if (b_vout) begin
            b_pulses++;
            if (bq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL big_spurious: valid_out with data %h, required no pulse", b_dout);
            end else begin
                b_e = bq.pop_front();
                chk("big_data", b_dout, b_e.d);
                chk("big_frame_done", 32'(b_fd), 32'(b_e.fd));
                chk("big_latency", cyc, b_e.cyc);
            end
        end else if (b_fd) begin
            n_chk++; n_fail++;
            $display("FAIL big_fd_alone: frame_done 1 without valid_out, required 0");
        end
    end

    task automatic drive_frame(input vec_t v, input int nb, input int maxgap);
        int   r, c, g;
        exp_t te;
        for (int b = 0; b < nb; b++) begin
            r = b / 4;
            c = b % 4;
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (g) begin
                @(negedge clk);
                s_vin = 1'b0;
                s_din = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            s_din = v.px[b];
            s_vin = 1'b1;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                te.d   = v.ex[(r / 2) * 2 + c / 2];
                te.fd  = (b == 15);
                te.cyc = cyc + 1;
                sq.push_back(te);
            end
        end
    endtask

    task automatic drain(input string name, input int n);
        @(negedge clk);
        s_vin = 1'b0;
        b_vin = 1'b0;
        repeat (n) @(negedge clk);
        chk({name, "_small_pending"}, 32'(sq.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_data_out"}, s_dout, 32'h0);
        chk({name, "_valid_out"}, 32'(s_vout), 32'h0);
        chk({name, "_frame_done"}, 32'(s_fd), 32'h0);
        chk({name, "_big_data_out"}, b_dout, 32'h0);
        chk({name, "_big_valid_out"}, 32'(b_vout), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tmp[16];
        int   r, c, k;
        exp_t te;

        tmp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        tbl[0].px = pk(tmp);
        tbl[0].ex = pk4(6, 8, 14, 16);
        tmp = '{99, 98, 97, 96, 95, 94, 93, 92, 91, 90, 89, 88, 87, 86, 85, 84};
        tbl[1].px = pk(tmp);
        tbl[1].ex = pk4(99, 97, 91, 89);
        tmp = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10, -11, -12, -13, -14, -15, -16};
        tbl[2].px = pk(tmp);
        tbl[2].px[5] = 32'h8000_0000;
        tbl[2].ex = pk4(0, 0, 0, 0);
        tmp = '{-5, 3, -1, -2, 2, -7, -3, -4, 10, 9, -8, 7, 1, -1, 6, -6};
        tbl[3].px = pk(tmp);
        tbl[3].ex = pk4(3, 0, 10, 7);
        tmp = '{0, 3, 0, 0, 1, 2, -1, 2, 0, -1, 1, 2, -3, 0, 3, 4};
        tbl[4].px = pk(tmp);
        tbl[4].px[0]  = 32'h7F80_0000;
        tbl[4].px[2]  = 32'h7FC0_0000;
        tbl[4].px[3]  = 32'h7F80_0000;
        tbl[4].px[8]  = 32'hFFC0_0000;
        tbl[4].px[13] = 32'hFF80_0000;
        tbl[4].ex[0] = 32'h7F80_0000;
        tbl[4].ex[1] = 32'h7FC0_0000;
        tbl[4].ex[2] = 32'h0;
        tbl[4].ex[3] = fp(4);
        tmp = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        tbl[5].px = pk(tmp);
        tbl[5].ex = pk4(5, 5, 5, 5);

        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // Every table frame back-to-back with no idle cycle between frames
        for (int i = 0; i < 6; i++) drive_frame(tbl[i], 16, 0);
        drain("table", 4);

        // Same raster frame with random gaps on valid_in
        drive_frame(tbl[0], 16, 3);
        drain("gaps", 4);

        // Abort after 7 beats; reset coincides with a valid beat that must be dropped
        drive_frame(tbl[0], 7, 0);
        drain("abort", 3);
        @(negedge clk);
        rst   = 1'b1;
        s_vin = 1'b1;
        s_din = fp(1000);
        @(negedge clk);
        chk_reset_state("midreset");
        rst   = 1'b0;
        s_vin = 1'b0;
        drive_frame(tbl[0], 16, 0);
        drain("fresh", 4);

        // 56x56 random frame including +Inf, +NaN and negatives
        for (int i = 0; i < 3136; i++) begin
            k = int'($urandom_range(0, 15));
            case (k)
                0:       bpx[i] = 32'h7F80_0000;
                1:       bpx[i] = 32'h7FC0_0000 | ($urandom & 32'h003F_FFFF);
                2:       bpx[i] = {1'b1, 31'($urandom)};
                3:       bpx[i] = 32'h8000_0000;
                default: bpx[i] = {1'b0, 31'($urandom)};
            endcase
        end
        for (int pr = 0; pr < 28; pr++) begin
            for (int pc = 0; pc < 28; pc++) begin
                bref[pr * 28 + pc] = ref_max(
                    ref_max(ref_relu(bpx[(2 * pr) * 56 + 2 * pc]),
                            ref_relu(bpx[(2 * pr) * 56 + 2 * pc + 1])),
                    ref_max(ref_relu(bpx[(2 * pr + 1) * 56 + 2 * pc]),
                            ref_relu(bpx[(2 * pr + 1) * 56 + 2 * pc + 1])));
            end
        end
        for (int b = 0; b < 3136; b++) begin
            r = b / 56;
            c = b % 56;
            @(negedge clk);
            b_din = bpx[b];
            b_vin = 1'b1;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                te.d   = bref[(r / 2) * 28 + c / 2];
                te.fd  = (b == 3135);
                te.cyc = cyc + 1;
                bq.push_back(te);
            end
        end
        drain("big", 4);
        chk("big_pending", 32'(bq.size()), 32'd0);
        chk("big_pulse_count", 32'(b_pulses), 32'd784);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
